play_decimator: RTL and testbench
=================================

// Module: play_decimator
// PURPOSE
//   Fast-playback sample-rate reducer: consumes one 16-bit signed audio sample per accepted input
//   beat and emits one sample per group of N = i_speed+1 inputs (N = 1..8).
//   Sits between the SRAM playback reader and the DAC serializer, in the fast-play path.
//   It is the counterpart of the slow-play interpolators, which turn 1 sample into N.
// PARAMETERS
//   DW      16  sample width, signed two's complement
//   SPD_W   3   speed field width; group size N = i_speed + 1
// PORTS
//   i_clk       in   1      system clock, single clock domain
//   i_rst_n     in   1      synchronous, active-low reset
//   i_flush     in   1      drop any partial group (stop/pause from the top FSM)
//   i_speed     in   SPD_W  group size minus one; sampled at group start only
//   i_data      in   DW     input sample
//   i_valid     in   1      input sample valid
//   o_ready     out  1      block can accept an input sample
//   o_data      out  DW     decimated output sample
//   o_valid     out  1      output sample valid
//   i_ready     in   1      downstream accepts the output sample
// BEHAVIOUR
//   - Reset (i_rst_n=0 at a clock edge): state=S_ACC, cnt=0, acc=0, o_valid=0, o_data=0, o_ready=1.
//     Reset wins over every other input, including mid-group and mid-output.
//   - Handshakes: input beat = i_valid & o_ready. Output beat = o_valid & i_ready.
//   - o_valid may not drop, and o_data may not change, until the output beat completes.
//   - FSM states:
//     * S_ACC: o_ready=1. On an input beat with cnt==0, latch n_lat = i_speed+1.
//       Each input beat folds the sample into acc and increments cnt.
//       When the beat makes cnt == n_lat, go to S_OUT and load o_data; cnt returns to 0.
//     * S_OUT: o_ready=0, o_valid=1. On an output beat, return to S_ACC with o_valid=0.
//   - Latency: o_valid rises on the cycle after the Nth input beat.
//     With N=1 and i_ready held high, throughput is 1 output per 2 clocks (no skid buffer).
//   - i_speed changes mid-group do not affect the current group; they take effect from the next
//     group start.
//   - i_flush in S_ACC: cnt=0, acc=0, current input beat discarded.
//     i_flush in S_OUT: the pending output still completes, with no flush effect on it.
//   - The counter wraps only via the cnt==n_lat compare; cnt never exceeds 8.
// CONFIGURATION
//   - AVERAGE_EN defined: o_data = round(mean of the N samples).
//     * acc is a signed DW+3 sum.
//     * o_data = (acc * RECIP[N] + 2^15) >>> 16, where RECIP is Q16 round(65536/N):
//       {65536,32768,21845,16384,13107,10923,9362,8192}.
//     * Result is saturated to the DW range.
//   - AVERAGE_EN undefined: o_data = the first sample of each group (pick decimation).
//     acc holds only that sample; no multiplier is instantiated.
// STRUCTURE
//   - Shared package play_pkg: state enum {S_ACC,S_OUT}, the RECIP_Q16 table, and the
//     localparams DW and SPD_W. The slow-play interpolators also use this package.
//   - One sub-module: play_avg_div, a combinational sum*RECIP, round, >>>16 and saturate stage.
//     It exists only under AVERAGE_EN.
// TESTING
//   1. Reset: hold i_rst_n=0 for 3 clocks with i_valid=1 -> o_valid=0, o_data=0, o_ready=1.
//      The first group after release starts at cnt=0.
//   2. i_speed=0, inputs 5,-7 with i_ready=1 -> outputs 5,-7, each one cycle after its input
//      beat; o_ready is low in the cycle o_valid is high.
//   3. i_speed=2, inputs 100,200,301 -> AVERAGE_EN: output 200. Pick mode: output 100.
//   4. i_speed=7, eight inputs of -32768 -> AVERAGE_EN: output -32768 (no overflow).
//      Pick mode: output -32768.
//   5. i_speed=3, change i_speed to 1 after 2 beats -> the group still closes after 4 beats;
//      the next group closes after 2 beats.
//   6. i_speed=3, flush after 2 beats, then inputs 4,8,12,16 -> a single output of 10
//      (AVERAGE_EN) or 4 (pick).
//   7. i_ready=0 for 5 cycles in S_OUT -> o_data stable, o_ready=0, and no input beats are
//      lost across the stall.

Source files
------------

// File: rtl/play_pkg.sv
// Shared definitions for the playback rate blocks (fast-play decimator and
// slow-play interpolators).
//   DW        sample width, signed two's complement
//   SPD_W     speed field width; group size N = speed + 1
//   state_e   S_ACC accumulates a group, S_OUT holds the result until taken
//   RECIP_Q16 Q16 reciprocals round(65536/N) for N = 1..8
package play_pkg;

  localparam int unsigned DW    = 16;
  localparam int unsigned SPD_W = 3;

  typedef enum logic {
    S_ACC,
    S_OUT
  } state_e;

  localparam logic [16:0] RECIP_Q16 [8] = '{
    17'd65536, 17'd32768, 17'd21845, 17'd16384,
    17'd13107, 17'd10923, 17'd9362,  17'd8192
  };

  // n is the group size 1..8; maps to table slot n-1.
  function automatic logic [16:0] recip_q16(input logic [SPD_W:0] n);
    logic [SPD_W:0] idx;
    idx = n - 1'b1;
    return RECIP_Q16[idx[SPD_W-1:0]];
  endfunction

endpackage

// File: rtl/play_avg_div.sv
// Combinational mean stage: o_data = sat((i_sum * RECIP_Q16[N] + 2^15) >>> 16).
// Only built when AVERAGE_EN is defined; pick mode has no multiplier.
//   i_sum   signed group sum, DW+3 bits
//   i_n     group size 1..8
//   o_data  rounded mean, saturated to the DW range
`ifdef AVERAGE_EN
module play_avg_div
  import play_pkg::*;
(
  input  logic signed [DW+2:0] i_sum,
  input  logic        [SPD_W:0] i_n,
  output logic signed [DW-1:0] o_data
);

  localparam int unsigned PW = 40;

  logic signed [PW-1:0] sum_ext;
  logic signed [PW-1:0] recip_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;

  always_comb begin
    sum_ext   = {{(PW-DW-3){i_sum[DW+2]}}, i_sum};
    recip_ext = $signed({{(PW-17){1'b0}}, recip_q16(i_n)});
    prod      = sum_ext * recip_ext + 40'sd32768;
    shifted   = prod >>> 16;
    if (shifted > 40'sd32767) begin
      o_data = 16'sh7fff;
    end else if (shifted < -40'sd32768) begin
      o_data = -16'sh8000;
    end else begin
      o_data = shifted[DW-1:0];
    end
  end

endmodule
`endif

// File: rtl/play_decimator.sv
// Fast-playback sample-rate reducer: one output sample per group of
// N = i_speed+1 accepted input samples.
// Build option: AVERAGE_EN defined -> output is the rounded mean of the group;
// undefined -> output is the first sample of the group (pick decimation).
// Ports:
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_flush            drop any partial group
//   i_speed            group size minus one, sampled at group start
//   i_data/i_valid/o_ready   input stream
//   o_data/o_valid/i_ready   output stream
module play_decimator
  import play_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  input  logic [SPD_W-1:0]     i_speed,
  input  logic signed [DW-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic signed [DW-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready
);

`ifdef AVERAGE_EN
  localparam int unsigned AW = DW + 3;
`else
  localparam int unsigned AW = DW;
`endif

  state_e                state_q, state_d;
  logic [SPD_W:0]        cnt_q, cnt_d;
  logic [SPD_W:0]        n_lat_q, n_lat_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [DW-1:0]  o_data_q, o_data_d;
  logic                  o_valid_q, o_valid_d;

  logic [SPD_W:0]        n_grp;
  logic [SPD_W:0]        cnt_inc;
  logic signed [AW-1:0]  acc_nxt;
  logic signed [DW-1:0]  result;

  // Group size in force for this beat: a fresh sample of i_speed at group
  // start, otherwise the value latched then.
  assign n_grp   = (cnt_q == '0) ? ({1'b0, i_speed} + 1'b1) : n_lat_q;
  assign cnt_inc = cnt_q + 1'b1;

`ifdef AVERAGE_EN
  assign acc_nxt = acc_q + {{(AW-DW){i_data[DW-1]}}, i_data};

  play_avg_div u_avg_div (
    .i_sum  (acc_nxt),
    .i_n    (n_grp),
    .o_data (result)
  );
`else
  // Only the first sample of a group is kept.
  assign acc_nxt = (cnt_q == '0) ? i_data : acc_q;
  assign result  = acc_nxt;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_lat_d   = n_lat_q;
    acc_d     = acc_q;
    o_data_d  = o_data_q;
    o_valid_d = o_valid_q;
    unique case (state_q)
      S_ACC: begin
        if (i_flush) begin
          cnt_d = '0;
          acc_d = '0;
        end else if (i_valid) begin
          if (cnt_q == '0) begin
            n_lat_d = n_grp;
          end
          if (cnt_inc == n_grp) begin
            state_d   = S_OUT;
            o_valid_d = 1'b1;
            o_data_d  = result;
            cnt_d     = '0;
            acc_d     = '0;
          end else begin
            cnt_d = cnt_inc;
            acc_d = acc_nxt;
          end
        end
      end
      S_OUT: begin
        // Flush is ignored here: the pending result always completes.
        if (i_ready) begin
          state_d   = S_ACC;
          o_valid_d = 1'b0;
        end
      end
      default: begin
        state_d   = S_ACC;
        o_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_ACC;
      cnt_q     <= '0;
      n_lat_q   <= '0;
      acc_q     <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_lat_q   <= n_lat_d;
      acc_q     <= acc_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign o_ready = (state_q == S_ACC);
  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;

endmodule

// File: tb/tb_play_decimator.sv
module tb_play_decimator;

  logic               clk;
  logic               rst_n;
  logic               flush;
  logic [2:0]         speed;
  logic signed [15:0] din;
  logic               din_valid;
  logic               din_ready;
  logic signed [15:0] dout;
  logic               dout_valid;
  logic               dout_ready;

  int unsigned n_total;
  int unsigned n_bad;

  play_decimator dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .i_speed (speed),
    .i_data  (din),
    .i_valid (din_valid),
    .o_ready (din_ready),
    .o_data  (dout),
    .o_valid (dout_valid),
    .i_ready (dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic signed [15:0] exp_q[$];
  bit          m_out;      // model is in the output-holding state
  int          m_cnt;
  int          m_n;
  longint      m_sum;
  longint      m_first;
  int unsigned m_nout;     // outputs consumed
  bit          chk_en;

  function automatic longint expected(input longint sum, input int n, input longint first);
`ifdef AVERAGE_EN
    longint recip [8];
    longint r;
    recip = '{65536, 32768, 21845, 16384, 13107, 10923, 9362, 8192};
    r = (sum * recip[n-1] + 32768) >>> 16;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
`else
    return first;
`endif
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_out = 0; m_cnt = 0; m_sum = 0; m_first = 0;
      exp_q.delete();
    end else if (!m_out) begin
      if (flush) begin
        m_cnt = 0; m_sum = 0;
      end else if (din_valid) begin
        if (m_cnt == 0) begin
          m_n = int'(speed) + 1;
          m_first = longint'(din);
        end
        m_sum += longint'(din);
        m_cnt++;
        if (m_cnt == m_n) begin
          exp_q.push_back(16'(expected(m_sum, m_n, m_first)));
          m_out = 1; m_cnt = 0; m_sum = 0;
        end
      end
    end else if (dout_ready) begin
      m_out = 0;
      m_nout++;
      void'(exp_q.pop_front());
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("o_valid", longint'(dout_valid), longint'(m_out));
      check("o_ready", longint'(din_ready), longint'(!m_out));
      if (m_out) begin
        if (exp_q.size() == 0) check("scoreboard_empty", 1, 0);
        else check("o_data", longint'(dout), longint'(exp_q[0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic signed [15:0] d);
    bit acc;
    int guard;
    @(negedge clk);
    din = d;
    din_valid = 1'b1;
    guard = 0;
    forever begin
      acc = din_ready;
      @(posedge clk);
      if (acc) break;
      guard++;
      if (guard > 50) begin
        check("send_timeout", 1, 0);
        break;
      end
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((m_out || exp_q.size() != 0) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("drain_timeout", 1, 0);
  endtask

  // Wait for the next output and compare it to an explicit constant.
  task automatic expect_out(input string tag, input longint v);
    int guard;
    guard = 0;
    while (!dout_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check({tag, "_timeout"}, 1, 0);
    else check(tag, longint'(dout), v);
  endtask

  int unsigned nout0;

  initial begin
    n_total = 0; n_bad = 0; m_nout = 0; chk_en = 0;
    rst_n = 1'b0; flush = 1'b0; speed = '0; din = 16'sd0;
    din_valid = 1'b1; dout_ready = 1'b1;

    // 1. reset with valid asserted
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_o_valid", longint'(dout_valid), 0);
    check("rst_o_data", longint'(dout), 0);
    check("rst_o_ready", longint'(din_ready), 1);
    din_valid = 1'b0;
    rst_n = 1'b1;
    chk_en = 1;

    // 2. N=1 pass-through
    speed = 3'd0;
    send(16'sd5);
    check("n1_first", longint'(dout), 5);
    drain();
    send(-16'sd7);
    check("n1_second", longint'(dout), -7);
    drain();

    // 3. N=3
    speed = 3'd2;
    fork
      begin send(16'sd100); send(16'sd200); send(16'sd301); end
`ifdef AVERAGE_EN
      expect_out("n3_out", 200);
`else
      expect_out("n3_out", 100);
`endif
    join
    drain();

    // 4. N=8 full-scale negative
    speed = 3'd7;
    fork
      for (int i = 0; i < 8; i++) send(-16'sd32768);
      expect_out("n8_neg_full", -32768);
    join
    drain();

    // 5. speed change mid-group
    speed = 3'd3;
    nout0 = m_nout;
    send(16'sd1); send(16'sd2);
    speed = 3'd1;
    send(16'sd3);
    check("spdchg_open", longint'(dout_valid), 0);
    send(16'sd4);
    check("spdchg_close4", longint'(dout_valid), 1);
    drain();
    send(16'sd50);
    check("spdchg_open2", longint'(dout_valid), 0);
    send(16'sd60);
    check("spdchg_close2", longint'(dout_valid), 1);
    drain();
    check("spdchg_nout", longint'(m_nout - nout0), 2);

    // 6. flush of a partial group
    speed = 3'd3;
    send(-16'sd900); send(16'sd777);
    @(negedge clk);
    flush = 1'b1; din_valid = 1'b1; din = 16'sd1234;
    @(negedge clk);
    flush = 1'b0; din_valid = 1'b0;
    nout0 = m_nout;
    fork
      begin send(16'sd4); send(16'sd8); send(16'sd12); send(16'sd16); end
`ifdef AVERAGE_EN
      expect_out("flush_out", 10);
`else
      expect_out("flush_out", 4);
`endif
    join
    drain();
    check("flush_nout", longint'(m_nout - nout0), 1);

    // 7. downstream stall with input pending
    speed = 3'd0;
    dout_ready = 1'b0;
    send(16'sd9);
    nout0 = m_nout;
    fork
      send(16'sd11);
      begin
        repeat (5) @(negedge clk);
        check("stall_data", longint'(dout), 9);
        dout_ready = 1'b1;
      end
    join
    drain();
    check("stall_nout", longint'(m_nout - nout0), 2);

    // 8. random groups with random backpressure
    for (int g = 0; g < 20; g++) begin
      speed = 3'($urandom_range(0, 7));
      dout_ready = 1'($urandom_range(0, 1));
      for (int k = 0; k <= int'(speed); k++) begin
        fork
          send(16'($urandom));
          begin @(negedge clk); dout_ready = 1'b1; end
        join
      end
      drain();
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
